// File: rtl/router_local_in_buffer_if.sv
// Local-port handshake bundle between the PE, the input buffer and the router switch.
// The master side drives flits and switch-ready; the slave side is the buffer itself.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 8
`endif

interface router_local_in_buffer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = `ROUTER_WIDTH
);
  logic                     in_data_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     upstream_credit;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   occupancy;
  logic                     overflow;

  modport master (
    output in_data_valid,
    output in_data,
    output out_ready,
    input  upstream_credit,
    input  out_valid,
    input  out_data,
    input  occupancy,
    input  overflow
  );

  modport slave (
    input  in_data_valid,
    input  in_data,
    input  out_ready,
    output upstream_credit,
    output out_valid,
    output out_data,
    output occupancy,
    output overflow
  );
endinterface

// File: rtl/router_local_in_buffer.sv
// Credit-based input buffer for the router's local (PE) port.
// Circular first-word-fall-through FIFO; every popped flit returns one credit
// to the PE on the following cycle. Flits arriving with no free slot are
// dropped and latch a sticky overflow flag.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 8
`endif

module router_local_in_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = `ROUTER_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  router_local_in_buffer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             valid_r;
  logic             overflow_r;
  logic             credit_r;

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [OCC_W-1:0] occ_next_s;

  // Push/pop/drop decisions and next occupancy; a pop frees the slot a full-buffer push needs.
  always_comb begin
    full_s     = 1'b0;
    pop_s      = 1'b0;
    push_s     = 1'b0;
    drop_s     = 1'b0;
    occ_next_s = occ_r;
    full_s     = (occ_r == OCC_FULL);
    pop_s      = valid_r & bus.out_ready;
    push_s     = bus.in_data_valid & (~full_s | pop_s);
    drop_s     = bus.in_data_valid & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_ONE;
      2'b01:   occ_next_s = occ_r - OCC_ONE;
      default: occ_next_s = occ_r;
    endcase
  end

  // Pointer, occupancy, flag and credit state; reset discards contents and any pending credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      occ_r      <= OCC_ZERO;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      credit_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      occ_r      <= occ_next_s;
      valid_r    <= (occ_next_s != OCC_ZERO);
      overflow_r <= overflow_r | drop_s;
      credit_r   <= pop_s;
    end
  end

  // Flit storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign bus.out_valid       = valid_r;
  assign bus.out_data        = mem_r[rd_ptr_r];
  assign bus.occupancy       = occ_r;
  assign bus.overflow        = overflow_r;
  assign bus.upstream_credit = credit_r;

endmodule

// File: tb/tb_router_local_in_buffer.sv
// Scoreboard bench for router_local_in_buffer (DEPTH=4, WIDTH=8).
// Stimulus pushes hand-determined accepted flits into a queue; a negedge
// monitor pops and compares on every head transfer and checks credit timing.
module tb_router_local_in_buffer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] sbq [$];
  logic exp_credit;

  router_local_in_buffer_if #(.DEPTH(4), .WIDTH(8)) bus ();

  router_local_in_buffer #(.DEPTH(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; acc marks a flit expected to be accepted.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic acc);
    bus.in_data_valid = v;
    bus.in_data       = d;
    bus.out_ready     = r;
    if (acc) sbq.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: credit must follow each transfer by exactly one cycle; data must match queue order.
  initial begin
    exp_credit = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_credit = 1'b0;
      end else begin
        check("credit", {31'd0, bus.upstream_credit}, {31'd0, exp_credit});
        exp_credit = bus.out_valid & bus.out_ready;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_data: got 0x%0h want nothing (queue empty)", bus.out_data);
          end else begin
            check("out_data", {24'd0, bus.out_data}, {24'd0, sbq.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.in_data_valid = 1'b0;
    bus.in_data       = 8'h00;
    bus.out_ready     = 1'b0;
    #1;
    check("rst_occ",    {29'd0, bus.occupancy}, 32'd0);
    check("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_ovf",    {31'd0, bus.overflow}, 32'd0);
    check("rst_credit", {31'd0, bus.upstream_credit}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill then drain
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    check("first_push_valid", {31'd0, bus.out_valid}, 32'd1);
    check("first_push_head", {24'd0, bus.out_data}, 32'hA1);
    step(1'b1, 8'hA2, 1'b0, 1'b1);
    step(1'b1, 8'hA3, 1'b0, 1'b1);
    step(1'b1, 8'hA4, 1'b0, 1'b1);
    check("fill_occ", {29'd0, bus.occupancy}, 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_occ", {29'd0, bus.occupancy}, 32'd0);

    // Full with simultaneous push/pop
    step(1'b1, 8'hB1, 1'b0, 1'b1);
    step(1'b1, 8'hB2, 1'b0, 1'b1);
    step(1'b1, 8'hB3, 1'b0, 1'b1);
    step(1'b1, 8'hB4, 1'b0, 1'b1);
    step(1'b1, 8'hB5, 1'b1, 1'b1);
    check("full_pushpop_occ", {29'd0, bus.occupancy}, 32'd4);
    check("full_pushpop_head", {24'd0, bus.out_data}, 32'hB2);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("b_drain_occ", {29'd0, bus.occupancy}, 32'd0);

    // Overflow
    step(1'b1, 8'hC1, 1'b0, 1'b1);
    step(1'b1, 8'hC2, 1'b0, 1'b1);
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    step(1'b1, 8'hC4, 1'b0, 1'b1);
    check("pre_ovf", {31'd0, bus.overflow}, 32'd0);
    step(1'b1, 8'hC6, 1'b0, 1'b0);
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    check("ovf_occ", {29'd0, bus.occupancy}, 32'd4);
    check("ovf_head", {24'd0, bus.out_data}, 32'hC1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("c_drain_occ", {29'd0, bus.occupancy}, 32'd0);
    check("ovf_sticky2", {31'd0, bus.overflow}, 32'd1);

    // Pointer wrap: streaming push+pop
    step(1'b1, 8'h00, 1'b1, 1'b1);
    check("wrap_occ0", {29'd0, bus.occupancy}, 32'd1);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b1);
      check("wrap_occ", {29'd0, bus.occupancy}, 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_end_occ", {29'd0, bus.occupancy}, 32'd0);

    // Reset mid-operation, between clock edges
    step(1'b1, 8'hE1, 1'b0, 1'b1);
    step(1'b1, 8'hE2, 1'b0, 1'b1);
    step(1'b1, 8'hE3, 1'b0, 1'b1);
    bus.in_data_valid = 1'b0;
    check("pre_rst_occ", {29'd0, bus.occupancy}, 32'd3);
    #2;
    rst = 1'b0;
    sbq.delete();
    #1;
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_occ",   {29'd0, bus.occupancy}, 32'd0);
    check("async_rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 8'hD7, 1'b0, 1'b1);
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_rst_head", {24'd0, bus.out_data}, 32'hD7);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Idle ready on empty buffer
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("idle_occ",   {29'd0, bus.occupancy}, 32'd0);
    check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 8'hF1, 1'b0, 1'b1);
    check("idle_then_push_head", {24'd0, bus.out_data}, 32'hF1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    check("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
